decoder_scan_nx2n: RTL and testbench

- Parametrised, registered N-to-2^N one-hot decoder. Successor to the fixed 3-to-8 combinational decoder.
- Two modes:
  - Direct: registered decode of an input address.
  - Scan: an internal prescaled counter rotates the active output through indices 0..scan_last. Used for multiplexed display digit/row drive.
- Sits between control logic and LED/7-segment common-line drivers.

---
 rtl/decoder_pkg.sv | 31 +++
 rtl/decoder_scan_nx2n_prescaler.sv | 35 +++
 rtl/decoder_scan_nx2n.sv | 97 +++++++++
 tb/tb_decoder_scan_nx2n.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the scanning N-to-2^N select decoder:
// mode encodings, the one-hot expansion and a width helper.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest address the one-hot helper supports; callers cast down to 2^N bits.
  localparam int MAX_N = 8;
  localparam int MAX_W = 256;

  function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] index);
    logic [MAX_W-1:0] vec_s;
    vec_s        = {MAX_W{1'b0}};
    vec_s[index] = 1'b1;
    return vec_s;
  endfunction

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    int width_s;
    width_s = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        width_s = i + 1;
      end
    end
    return (width_s < 1) ? 1 : width_s;
  endfunction

endpackage

// File: rtl/decoder_scan_nx2n_prescaler.sv
// Scan-step prescaler: counts enabled clocks 0..TICK_DIV-1 and flags the
// terminal count so the top level can advance its index.
module scan_prescaler
  import decoder_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset_p,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int            PW   = clog2_min1(TICK_DIV);
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  logic [PW-1:0] count_r;

  assign tick = run && (count_r == TERM);

  // Prescale counter: cleared in direct mode, frozen while disabled.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      count_r <= {PW{1'b0}};
    end else if (clear) begin
      count_r <= {PW{1'b0}};
    end else if (run) begin
      count_r <= tick ? {PW{1'b0}} : count_r + PW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/decoder_scan_nx2n.sv
// Registered N-to-2^N select decoder with direct and rotating-scan modes,
// driving multiplexed LED / 7-segment common lines.
module decoder_scan_nx2n
  import decoder_pkg::*;
#(
  parameter int N          = 3,
  parameter int TICK_DIV   = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                reset_p,
  input  logic                en,
  input  logic                mode,
  input  logic [N-1:0]        addr,
  input  logic [N-1:0]        scan_last,
  output logic [(1<<N)-1:0]   dout,
  output logic [N-1:0]        idx,
  output logic                strobe
);

  localparam int               OUT_W    = 1 << N;
  localparam logic [OUT_W-1:0] INACTIVE = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  logic [N-1:0]     idx_r;
  logic [OUT_W-1:0] dout_r;
  logic             strobe_r;

  logic [N-1:0]     idx_next_s;
  logic [OUT_W-1:0] sel_s;
  logic [OUT_W-1:0] dout_next_s;
  logic             strobe_next_s;
  logic             tick_s;
  logic             clear_s;
  logic             run_s;

  assign clear_s = en && (mode == MODE_DIRECT);
  assign run_s   = en && (mode == MODE_SCAN);

  scan_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset_p (reset_p),
    .clear   (clear_s),
    .run     (run_s),
    .tick    (tick_s)
  );

  // Next index/select: dout is decoded from idx_next so both registers agree.
  always_comb begin
    idx_next_s    = idx_r;
    strobe_next_s = 1'b0;
    sel_s         = {OUT_W{1'b0}};
    if (en) begin
      case (mode)
        MODE_DIRECT: begin
          idx_next_s = addr;
        end
        MODE_SCAN: begin
          if (tick_s) begin
            strobe_next_s = 1'b1;
            // Wrap test first, so the increment never overflows and an
            // index above a freshly lowered scan_last lasts one step only.
            idx_next_s    = (idx_r >= scan_last) ? {N{1'b0}} : idx_r + N'(1);
          end else begin
            idx_next_s = idx_r;
          end
        end
        default: begin
          idx_next_s = idx_r;
        end
      endcase
      sel_s = OUT_W'(onehot(MAX_N'(idx_next_s)));
    end else begin
      sel_s = {OUT_W{1'b0}};
    end
    dout_next_s = ACTIVE_LOW ? ~sel_s : sel_s;
  end

  // Output registers; every port is driven straight from these flops.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      idx_r    <= {N{1'b0}};
      dout_r   <= INACTIVE;
      strobe_r <= 1'b0;
    end else begin
      idx_r    <= idx_next_s;
      dout_r   <= dout_next_s;
      strobe_r <= strobe_next_s;
    end
  end

  assign dout   = dout_r;
  assign idx    = idx_r;
  assign strobe = strobe_r;

endmodule

// File: tb/tb_decoder_scan_nx2n.sv
// Scoreboard bench: u0 is N=3/TICK_DIV=4/active-high, u1 is N=3/TICK_DIV=1/
// active-low; both see the same stimulus with per-cycle expected values.
module tb_decoder_scan_nx2n;

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic       en = 1'b1;
  logic       mode = 1'b1;
  logic [2:0] addr = 3'd0;
  logic [2:0] scan_last = 3'd5;

  logic [7:0] dout0, dout1;
  logic [2:0] idx0, idx1;
  logic       strobe0, strobe1;

  always #5 clk = ~clk;

  decoder_scan_nx2n #(.N(3), .TICK_DIV(4), .ACTIVE_LOW(1'b0)) u0 (
    .clk(clk), .reset_p(reset_p), .en(en), .mode(mode), .addr(addr),
    .scan_last(scan_last), .dout(dout0), .idx(idx0), .strobe(strobe0));

  decoder_scan_nx2n #(.N(3), .TICK_DIV(1), .ACTIVE_LOW(1'b1)) u1 (
    .clk(clk), .reset_p(reset_p), .en(en), .mode(mode), .addr(addr),
    .scan_last(scan_last), .dout(dout1), .idx(idx1), .strobe(strobe1));

  typedef struct {
    int         cyc;
    int         which;
    logic [7:0] dout;
    logic [2:0] idx;
    logic       strobe;
    string      name;
  } exp_t;

  exp_t       sb[$];
  int         cyc    = 0;
  int         total  = 0;
  int         bad    = 0;
  int         pushed = 0;
  logic [7:0] oh [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  task automatic drive(input logic r, input logic e, input logic m,
                       input logic [2:0] a, input logic [2:0] sl);
    @(negedge clk);
    reset_p   = r;
    en        = e;
    mode      = m;
    addr      = a;
    scan_last = sl;
  endtask

  // Expectation for the outputs right after the coming rising edge.
  task automatic push_exp(input int which, input string name, input logic [7:0] d,
                          input int i, input logic s);
    exp_t e;
    e.cyc    = cyc + 1;
    e.which  = which;
    e.dout   = d;
    e.idx    = 3'(i);
    e.strobe = s;
    e.name   = name;
    sb.push_back(e);
    pushed++;
  endtask

  task automatic push_pair(input string name, input int i0, input logic s0,
                           input int i1, input logic s1);
    push_exp(0, name, oh[i0], i0, s0);
    push_exp(1, name, ~oh[i1], i1, s1);
  endtask

  // Monitor: compare every queued expectation 1ns after its edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t       e;
        logic [7:0] d;
        logic [2:0] i;
        logic       s;
        e = sb.pop_front();
        d = (e.which == 0) ? dout0 : dout1;
        i = (e.which == 0) ? idx0 : idx1;
        s = (e.which == 0) ? strobe0 : strobe1;
        total++;
        if (e.cyc != cyc || d !== e.dout || i !== e.idx || s !== e.strobe) begin
          bad++;
          $display("FAIL %s u%0d cyc=%0d (due %0d): got dout=%h idx=%0d strobe=%b, want dout=%h idx=%0d strobe=%b",
                   e.name, e.which, cyc, e.cyc, d, i, s, e.dout, e.idx, e.strobe);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two clocks with en=1, mode=scan.
    repeat (2) begin
      drive(1'b1, 1'b1, 1'b1, 3'd0, 3'd5);
      push_exp(0, "reset", 8'h00, 0, 1'b0);
      push_exp(1, "reset", 8'hFF, 0, 1'b0);
    end

    // Direct sweep, one address per clock, checked every cycle.
    for (int a = 0; a < 8; a++) begin
      drive(1'b0, 1'b1, 1'b0, 3'(a), 3'd5);
      push_pair("direct", a, 1'b0, a, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b0, 3'd0, 3'd5);
    push_pair("direct0", 0, 1'b0, 0, 1'b0);

    // Scan to scan_last=5: u0 steps every 4th clock, u1 every clock.
    for (int k = 1; k <= 38; k++) begin
      drive(1'b0, 1'b1, 1'b1, 3'd0, 3'd5);
      push_pair("scan_wrap", (k / 4) % 6, (k % 4) == 0, k % 6, 1'b1);
    end

    // u0 now at idx=3 with prescaler=2; disable for 5 clocks.
    repeat (5) begin
      drive(1'b0, 1'b0, 1'b1, 3'd0, 3'd5);
      push_exp(0, "disabled", 8'h00, 3, 1'b0);
      push_exp(1, "disabled", 8'hFF, 2, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b1, 3'd0, 3'd5);
    push_pair("resume1", 3, 1'b0, 3, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 3'd0, 3'd5);
    push_pair("resume2", 4, 1'b1, 4, 1'b1);

    // scan_last lowered to 1 while idx=4.
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 1'b1, 1'b1, 3'd0, 3'd1);
      push_pair("last_lowered", (k == 4) ? 0 : 4, k == 4, (k % 2 == 1) ? 0 : 1, 1'b1);
    end

    // scan_last = 0: index parked at 0, strobe keeps pulsing.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b1, 1'b1, 3'd0, 3'd0);
      push_pair("last_zero", 0, (k % 4) == 0, 0, 1'b1);
    end

    // Scan up to idx=2 on u0.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b1, 1'b1, 3'd0, 3'd5);
      push_pair("scan_to2", k / 4, (k % 4) == 0, k % 6, 1'b1);
    end

    // Scan -> direct with addr=6.
    drive(1'b0, 1'b1, 1'b0, 3'd6, 3'd5);
    push_pair("to_direct", 6, 1'b0, 6, 1'b0);

    // Direct -> scan: first step TICK_DIV clocks later.
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, 1'b1, 1'b1, 3'd0, 3'd7);
      push_pair("to_scan", (k >= 4) ? 7 : 6, k == 4, (6 + k) % 8, 1'b1);
    end

    // Reset mid-scan.
    drive(1'b1, 1'b1, 1'b1, 3'd0, 3'd7);
    push_exp(0, "reset_mid", 8'h00, 0, 1'b0);
    push_exp(1, "reset_mid", 8'hFF, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 3'd0, 3'd7);
    push_exp(0, "post_reset_off", 8'h00, 0, 1'b0);
    push_exp(1, "post_reset_off", 8'hFF, 0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 3'd0, 3'd7);
    push_pair("post_reset_scan", 0, 1'b0, 1, 1'b1);

    repeat (3) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL %s u%0d: expectation for cyc=%0d never checked", e.name, e.which, e.cyc);
    end

    if (total == 0) begin
      bad++;
      $display("FAIL no expectations were checked");
    end
    if (total != pushed) begin
      bad++;
      $display("FAIL checked %0d of %0d expectations", total, pushed);
    end
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %0d expectations left in queue", sb.size());
    end
    if (bad == 0) begin
      $display("PASS total=%0d", total);
    end else begin
      $display("FAIL total=%0d bad=%0d", total, bad);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
